// File: rtl/shift_seq8_pkg.sv
// Shared definitions for the 8-bit shift sequencer: widths, shifter command
// codes, request op encodings, FSM states and the request-to-command mapping.
// Optional build macro: SHIFT_SEQ_ROR_EN (request op 11 becomes rotate right).
package shift_seq8_pkg;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned AMT_W    = 3;
  localparam int unsigned STEP_MAX = 3;

  typedef enum logic [2:0] {
    CmdNop  = 3'b000,
    CmdLoad = 3'b001,
    CmdLsl  = 3'b010,
    CmdLsr  = 3'b011,
    CmdAsr  = 3'b100,
    CmdRor  = 3'b101
  } cmd_op_e;

  typedef enum logic [1:0] {
    ReqLsl = 2'b00,
    ReqLsr = 2'b01,
    ReqAsr = 2'b10,
    ReqRor = 2'b11
  } req_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StLoad  = 2'b01,
    StShift = 2'b10,
    StResp  = 2'b11
  } state_e;

  // Shifter command issued for each step of a request op.
  function automatic cmd_op_e req_to_cmd(req_op_e op);
    cmd_op_e cmd;
    case (op)
      ReqLsl:  cmd = CmdLsl;
      ReqLsr:  cmd = CmdLsr;
      ReqAsr:  cmd = CmdAsr;
`ifdef SHIFT_SEQ_ROR_EN
      ReqRor:  cmd = CmdRor;
`else
      ReqRor:  cmd = CmdNop;
`endif
      default: cmd = CmdNop;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/shift_seq8_if.sv
// Request / response / shifter-command bundle of the shift sequencer.
// master: request source and response sink; slave: the sequencer.
interface shift_seq8_if;
  import shift_seq8_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [AMT_W-1:0] req_amt;
  logic [WIDTH-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [2:0]       cmd_op;
  logic [1:0]       cmd_shamt;
  logic             busy;

  modport master (
    output req_valid, req_op, req_amt, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, cmd_op, cmd_shamt, busy
  );

  modport slave (
    input  req_valid, req_op, req_amt, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, cmd_op, cmd_shamt, busy
  );

endinterface

// File: rtl/shift_seq8_step8.sv
// Combinational single-step shifter (0..3 positions) mirroring the datapath
// shifter, used to keep the sequencer's shadow register in step.
// Optional build macro: SHIFT_SEQ_ROR_EN (adds the rotate-right command).
module shift_seq8_step8
  import shift_seq8_pkg::*;
(
  input  cmd_op_e          op_i,
  input  logic [1:0]       shamt_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] d_o
);

  // One shift step; any non-shift command passes the data through.
  always_comb begin
    d_o = d_i;
    case (op_i)
      CmdLsl: d_o = d_i << shamt_i;
      CmdLsr: d_o = d_i >> shamt_i;
      CmdAsr: d_o = $signed(d_i) >>> shamt_i;
`ifdef SHIFT_SEQ_ROR_EN
      // shamt 0 shifts left by WIDTH, which yields zero and keeps d_i intact.
      CmdRor: d_o = (d_i >> shamt_i) | (d_i << (WIDTH - 32'(shamt_i)));
`endif
      default: d_o = d_i;
    endcase
  end

endmodule

// File: rtl/shift_seq8.sv
// Shift sequencer: accepts one shift request, issues LOAD then shift steps of
// at most STEP_MAX onto the shifter command port, tracks the result in a
// shadow register and returns it over a valid/ready response.
// Command outputs are registered, so each command appears one cycle after
// the state that produced it.
// Optional build macro: SHIFT_SEQ_ROR_EN (request op 11 rotates right instead
// of passing the operand through unchanged).
module shift_seq8
  import shift_seq8_pkg::*;
(
  input logic         clk,
  input logic         reset,
  shift_seq8_if.slave bus
);

  state_e           state_q, state_d;
  req_op_e          op_q, op_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             rsp_valid_q, rsp_valid_d;
  cmd_op_e          cmd_op_q, cmd_op_d;
  logic [1:0]       cmd_shamt_q, cmd_shamt_d;
  logic             busy_q, busy_d;

  logic             passthru;
  logic [1:0]       step;
  logic [WIDTH-1:0] step_out;
  cmd_op_e          shift_cmd;

`ifdef SHIFT_SEQ_ROR_EN
  assign passthru = 1'b0;
`else
  assign passthru = (op_q == ReqRor);
`endif

  assign shift_cmd = req_to_cmd(op_q);
  assign step      = (rem_q > AMT_W'(STEP_MAX)) ? 2'(STEP_MAX) : rem_q[1:0];

  shift_seq8_step8 u_step (
    .op_i    (shift_cmd),
    .shamt_i (step),
    .d_i     (shadow_q),
    .d_o     (step_out)
  );

  // Next state, datapath updates and next registered outputs.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rem_d       = rem_q;
    data_d      = data_q;
    shadow_d    = shadow_q;
    rsp_valid_d = 1'b0;
    cmd_op_d    = CmdNop;
    cmd_shamt_d = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          op_d    = req_op_e'(bus.req_op);
          rem_d   = bus.req_amt;
          data_d  = bus.req_data;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cmd_op_d = CmdLoad;
        shadow_d = data_q;
        state_d  = (rem_q != '0 && !passthru) ? StShift : StResp;
      end
      StShift: begin
        cmd_op_d    = shift_cmd;
        cmd_shamt_d = step;
        shadow_d    = step_out;
        rem_d       = rem_q - {1'b0, step};
        if (rem_q <= AMT_W'(STEP_MAX)) begin
          state_d = StResp;
        end
      end
      StResp: begin
        // rsp_valid rises the cycle after entry and falls on the handshake edge.
        if (rsp_valid_q && bus.rsp_ready) begin
          state_d = StIdle;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= ReqLsl;
      rem_q       <= '0;
      data_q      <= '0;
      shadow_q    <= '0;
      rsp_valid_q <= 1'b0;
      cmd_op_q    <= CmdNop;
      cmd_shamt_q <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rem_q       <= rem_d;
      data_q      <= data_d;
      shadow_q    <= shadow_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_shamt_q <= cmd_shamt_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = shadow_q;
  assign bus.cmd_op    = cmd_op_q;
  assign bus.cmd_shamt = cmd_shamt_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_shift_seq8.sv
// Self-checking bench for shift_seq8: table of requests with expected result
// and latency, scoreboard queues for responses and command streams, plus
// hand-written sequences for response back-pressure and mid-shift reset.
module tb_shift_seq8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  shift_seq8_if bus_if ();

  shift_seq8 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  typedef struct {
    logic [1:0] op;
    logic [2:0] amt;
    logic [7:0] data;
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         lat;
  } exp_t;

  vec_t       vecs[8];
  exp_t       sb_q[$];
  logic [4:0] exp_cmd_q[$];
  logic [4:0] obs_cmd_q[$];
  int         n_chk  = 0;
  int         n_pass = 0;

  // Every non-NOP shifter command, one sample per cycle.
  always @(negedge clk) begin
    if (!reset && bus_if.cmd_op !== 3'b000) begin
      obs_cmd_q.push_back({bus_if.cmd_op, bus_if.cmd_shamt});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected command stream: LOAD, then steps of 3 with the remainder last.
  task automatic push_exp_cmds(input logic [1:0] op, input logic [2:0] amt);
    int         r;
    logic [2:0] code;
    logic       pass;
    code = 3'b010 + {1'b0, op};
`ifdef SHIFT_SEQ_ROR_EN
    pass = 1'b0;
`else
    pass = (op == 2'b11);
`endif
    exp_cmd_q.push_back(5'b001_00);
    r = pass ? 0 : int'(amt);
    while (r > 0) begin
      int s;
      s = (r >= 3) ? 3 : r;
      exp_cmd_q.push_back({code, 2'(s)});
      r -= s;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] amt, input logic [7:0] data,
                       input logic [7:0] exp_data, input int exp_lat);
    int   n;
    exp_t e;
    @(negedge clk);
    bus_if.req_op    = op;
    bus_if.req_amt   = amt;
    bus_if.req_data  = data;
    bus_if.req_valid = 1'b1;
    n = 0;
    while (bus_if.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 20), 32'd1);
    @(posedge clk);
    e.data = exp_data;
    e.lat  = exp_lat;
    sb_q.push_back(e);
    push_exp_cmds(op, amt);
    #1;
    bus_if.req_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until rsp_valid rises.
  task automatic wait_rsp();
    int   n;
    exp_t e;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (bus_if.rsp_valid === 1'b1) break;
    end
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("rsp_latency", 32'(n), 32'(e.lat));
      check("rsp_data", 32'(bus_if.rsp_data), 32'(e.data));
    end
  endtask

  task automatic compare_cmds();
    check("cmd_count", 32'(obs_cmd_q.size()), 32'(exp_cmd_q.size()));
    for (int i = 0; i < obs_cmd_q.size() && i < exp_cmd_q.size(); i++) begin
      check("cmd_op_shamt", 32'(obs_cmd_q[i]), 32'(exp_cmd_q[i]));
    end
    obs_cmd_q.delete();
    exp_cmd_q.delete();
  endtask

  task automatic release_rsp();
    @(negedge clk);
    bus_if.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rsp_drop", 32'(bus_if.rsp_valid), 32'd0);
    check("idle_after_rsp", 32'(bus_if.req_ready), 32'd1);
    bus_if.rsp_ready = 1'b0;
    compare_cmds();
  endtask

  initial begin
    vecs[0] = '{2'b00, 3'd5, 8'hB3, 8'h60, 4};
    vecs[1] = '{2'b10, 3'd7, 8'h80, 8'hFF, 5};
    vecs[2] = '{2'b01, 3'd0, 8'h5A, 8'h5A, 2};
    vecs[3] = '{2'b01, 3'd3, 8'hF0, 8'h1E, 3};
    vecs[4] = '{2'b00, 3'd7, 8'h01, 8'h80, 5};
    vecs[5] = '{2'b10, 3'd3, 8'h7C, 8'h0F, 3};
    vecs[6] = '{2'b01, 3'd6, 8'hFF, 8'h03, 4};
`ifdef SHIFT_SEQ_ROR_EN
    vecs[7] = '{2'b11, 3'd4, 8'h1E, 8'hE1, 4};
`else
    vecs[7] = '{2'b11, 3'd4, 8'h1E, 8'h1E, 2};
`endif

    bus_if.req_valid = 1'b0;
    bus_if.req_op    = 2'b00;
    bus_if.req_amt   = 3'd0;
    bus_if.req_data  = 8'h00;
    bus_if.rsp_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("rst_cmd_op", 32'(bus_if.cmd_op), 32'd0);
    check("rst_cmd_shamt", 32'(bus_if.cmd_shamt), 32'd0);
    check("rst_rsp_data", 32'(bus_if.rsp_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_req_ready", 32'(bus_if.req_ready), 32'd1);

    // Table-driven requests.
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].op, vecs[i].amt, vecs[i].data, vecs[i].exp_data, vecs[i].exp_lat);
      wait_rsp();
      release_rsp();
    end

    // Response back-pressure with a request pulsed while busy.
    issue(2'b10, 3'd2, 8'h90, 8'hE4, 3);
    wait_rsp();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_if.req_valid = (i == 1);
      bus_if.req_op    = 2'b00;
      bus_if.req_amt   = 3'd1;
      bus_if.req_data  = 8'h11;
      @(posedge clk);
      #1;
      check("hold_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
      check("hold_rsp_data", 32'(bus_if.rsp_data), 32'hE4);
      check("hold_req_ready", 32'(bus_if.req_ready), 32'd0);
    end
    @(negedge clk);
    bus_if.rsp_ready = 1'b1;
    bus_if.req_valid = 1'b1;
    @(posedge clk);
    #1;
    check("release_rsp_drop", 32'(bus_if.rsp_valid), 32'd0);
    check("release_not_accepted", 32'(bus_if.busy), 32'd0);
    check("release_req_ready", 32'(bus_if.req_ready), 32'd1);
    bus_if.rsp_ready = 1'b0;
    compare_cmds();
    issue(2'b00, 3'd1, 8'h11, 8'h22, 3);
    wait_rsp();
    release_rsp();

    // Reset asserted in the middle of SHIFT.
    issue(2'b00, 3'd7, 8'h01, 8'h80, 5);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(bus_if.busy), 32'd0);
    check("midrst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("midrst_cmd_op", 32'(bus_if.cmd_op), 32'd0);
    check("midrst_cmd_shamt", 32'(bus_if.cmd_shamt), 32'd0);
    sb_q.delete();
    exp_cmd_q.delete();
    @(negedge clk);
    obs_cmd_q.delete();
    reset = 1'b0;
    issue(2'b01, 3'd3, 8'hF0, 8'h1E, 3);
    wait_rsp();
    release_rsp();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
